// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multi-cycle multiply/divide unit with HI/LO result registers. It sits
//   beside the ALU in the EX stage. When an operation is issued, the result
//   is computed into a holding register. busy then stays high for a fixed
//   latency, and the result is committed to HI/LO on the last busy edge.
//
//   Optional feature: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
//   (ops 6-9). These ops accumulate into {HI,LO}.
//
// Parameters:
//   WIDTH       operand and HI/LO width in bits
//   MULT_CYCLES busy cycles for multiply-class ops (>= 1)
//   DIV_CYCLES  busy cycles for divide ops (>= 1)
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-high reset
//   start   in   issue strobe
//   MDU_op  in   [3:0] op select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI,
//                5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU
//   A       in   [WIDTH-1:0] rs operand
//   B       in   [WIDTH-1:0] rt operand
//   busy    out  high while an operation is in flight
//   HI      out  [WIDTH-1:0] HI register
//   LO      out  [WIDTH-1:0] LO register
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       MDU_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0]    MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0]    DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

  // Two's complement magnitude. The most-negative value maps to 2^(WIDTH-1),
  // which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    mag = v[WIDTH-1] ? (~v + ONE) : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    neg = ~v + ONE;
  endfunction

  logic [0:0]         state_r;
  logic               busy_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [2*WIDTH-1:0] res_r;
  logic               commit_r;

  logic               issue_s;
  logic [CW-1:0]      load_s;
  logic [2*WIDTH-1:0] res_s;
  logic               commit_s;

  logic [2*WIDTH-1:0] sprod_s;
  logic [2*WIDTH-1:0] uprod_s;
  logic               b_nz_s;
  logic [WIDTH-1:0]   den_s;
  logic [WIDTH-1:0]   mq_s;
  logic [WIDTH-1:0]   mr_s;
  logic [WIDTH-1:0]   squo_s;
  logic [WIDTH-1:0]   srem_s;
  logic [WIDTH-1:0]   uquo_s;
  logic [WIDTH-1:0]   urem_s;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc_s;
  assign acc_s = {hi_r, lo_r};
`endif

  // Sign-extending both operands to 2*WIDTH makes the truncated unsigned product
  // equal to the signed product.
  assign sprod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  assign uprod_s = {ZERO, A} * {ZERO, B};

  // A zero divisor is replaced by 1 so the divider stays defined. The result
  // is not committed in that case.
  assign b_nz_s = (B != ZERO);
  assign den_s  = b_nz_s ? B : ONE;
  assign uquo_s = A / den_s;
  assign urem_s = A % den_s;
  assign mq_s   = mag(A) / mag(den_s);
  assign mr_s   = mag(A) % mag(den_s);
  // Truncation toward zero: the quotient sign is the XOR of the operand signs,
  // and the remainder follows the dividend. Overflow (MIN / -1) falls out as
  // LO = MIN, HI = 0.
  assign squo_s = (A[WIDTH-1] ^ den_s[WIDTH-1]) ? neg(mq_s) : mq_s;
  assign srem_s = A[WIDTH-1] ? neg(mr_s) : mr_s;

  // Decode the op into issue/latency/result/commit-enable.
  always_comb begin
    issue_s  = 1'b0;
    load_s   = {CW{1'b0}};
    res_s    = {(2*WIDTH){1'b0}};
    commit_s = 1'b0;
    case (MDU_op)
      OP_MULT:  begin issue_s = 1'b1; load_s = MULT_LOAD; res_s = sprod_s; commit_s = 1'b1; end
      OP_MULTU: begin issue_s = 1'b1; load_s = MULT_LOAD; res_s = uprod_s; commit_s = 1'b1; end
      OP_DIV:   begin issue_s = 1'b1; load_s = DIV_LOAD; res_s = {srem_s, squo_s}; commit_s = b_nz_s; end
      OP_DIVU:  begin issue_s = 1'b1; load_s = DIV_LOAD; res_s = {urem_s, uquo_s}; commit_s = b_nz_s; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin issue_s = 1'b1; load_s = MULT_LOAD; res_s = acc_s + sprod_s; commit_s = 1'b1; end
      OP_MADDU: begin issue_s = 1'b1; load_s = MULT_LOAD; res_s = acc_s + uprod_s; commit_s = 1'b1; end
      OP_MSUB:  begin issue_s = 1'b1; load_s = MULT_LOAD; res_s = acc_s - sprod_s; commit_s = 1'b1; end
      OP_MSUBU: begin issue_s = 1'b1; load_s = MULT_LOAD; res_s = acc_s - uprod_s; commit_s = 1'b1; end
`endif
      default:  begin issue_s = 1'b0; load_s = {CW{1'b0}}; commit_s = 1'b0; end
    endcase
  end

  // IDLE/RUN FSM, latency counter, and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      busy_r   <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      hi_r     <= ZERO;
      lo_r     <= ZERO;
      res_r    <= {(2*WIDTH){1'b0}};
      commit_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && issue_s) begin
            state_r  <= RUN;
            busy_r   <= 1'b1;
            cnt_r    <= load_s;
            res_r    <= res_s;
            commit_r <= commit_s;
          end else if (start && (MDU_op == OP_MTHI)) begin
            hi_r <= A;
          end else if (start && (MDU_op == OP_MTLO)) begin
            lo_r <= A;
          end else begin
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          // start is ignored here. The edge that takes the counter to 0 commits.
          if (cnt_r == CNT_ONE) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            if (commit_r) begin
              hi_r <= res_r[2*WIDTH-1:WIDTH];
              lo_r <= res_r[WIDTH-1:0];
            end else begin
              hi_r <= hi_r;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed testbench for mult_div_unit using the default parameters
//   (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10). Inputs are driven on the falling
//   edge and outputs are sampled on the falling edge.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_fail;

  mult_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .MDU_op (op_in),
    .A      (a_in),
    .B      (b_in),
    .busy   (busy),
    .HI     (hi),
    .LO     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one rising edge. Returns at the falling edge after the issue edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op_in = op; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count falling edges that see busy high. The count is bounded so a stuck
  // busy cannot hang the run.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op_in = 4'd0; a_in = 32'd0; b_in = 32'd0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 00000000", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 00000000", lo); end
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int cyc;
    issue(4'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle(cyc);
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL mult_busy got %0d want 5", cyc); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo got %h want fffffffa", lo); end
    issue(4'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle(cyc);
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL multu_busy got %0d want 5", cyc); end
    n_checks++; if (hi !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_hi got %h want 00000001", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo got %h want fffffffe", lo); end
  endtask

  task automatic test_div;
    int cyc;
    issue(4'd2, 32'hFFFF_FFF9, 32'd2);            // -7 / 2 = -3 rem -1
    wait_idle(cyc);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL div_busy got %0d want 10", cyc); end
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", hi); end
    issue(4'd3, 32'd7, 32'd0);                    // divide by zero leaves HI/LO
    wait_idle(cyc);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL divz_busy got %0d want 10", cyc); end
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL divz_lo got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divz_hi got %h want ffffffff", hi); end
    issue(4'd2, 32'd7, 32'hFFFF_FFFE);            // 7 / -2 = -3 rem 1
    wait_idle(cyc);
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL divneg_lo got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'h0000_0001) begin n_fail++; $display("FAIL divneg_hi got %h want 00000001", hi); end
    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);    // signed overflow
    wait_idle(cyc);
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_lo got %h want 80000000", lo); end
    n_checks++; if (hi !== 32'h0000_0000) begin n_fail++; $display("FAIL divovf_hi got %h want 00000000", hi); end
    issue(4'd3, 32'hFFFF_FFF9, 32'd7);            // 4294967289 / 7 = 613566755 rem 4
    wait_idle(cyc);
    n_checks++; if (lo !== 32'h2492_4923) begin n_fail++; $display("FAIL divu_lo got %h want 24924923", lo); end
    n_checks++; if (hi !== 32'h0000_0004) begin n_fail++; $display("FAIL divu_hi got %h want 00000004", hi); end
  endtask

  task automatic test_mt;
    // LO is 24924923 from the previous test.
    issue(4'd4, 32'h1234_5678, 32'd0);
    n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_hi got %h want 12345678", hi); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy got %0b want 0", busy); end
    n_checks++; if (lo !== 32'h2492_4923) begin n_fail++; $display("FAIL mthi_lo got %h want 24924923", lo); end
    issue(4'd5, 32'hCAFE_F00D, 32'd0);
    n_checks++; if (lo !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mtlo_lo got %h want cafef00d", lo); end
    n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo_hi got %h want 12345678", hi); end
  endtask

  task automatic test_start_during_run;
    int cyc;
    issue(4'd0, 32'd3, 32'd4);
    // MTLO plus new operands arrive while the MULT is running.
    start = 1'b1; op_in = 4'd5; a_in = 32'hDEAD_BEEF; b_in = 32'd9;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (lo !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL run_mtlo_lo got %h want cafef00d", lo); end
    wait_idle(cyc);
    n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL run_busy_rest got %0d want 4", cyc); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL run_hi got %h want 00000000", hi); end
    n_checks++; if (lo !== 32'd12) begin n_fail++; $display("FAIL run_lo got %h want 0000000c", lo); end
  endtask

  task automatic test_madd;
    int cyc;
    issue(4'd4, 32'h0, 32'd0);
    issue(4'd5, 32'hFFFF_FFFF, 32'd0);
    issue(4'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    wait_idle(cyc);
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL maddu_busy got %0d want 5", cyc); end
    n_checks++; if (hi !== 32'h1) begin n_fail++; $display("FAIL maddu_hi got %h want 00000001", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL maddu_lo got %h want 00000000", lo); end
`else
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL maddu_nop_busy got %0b want 0", busy); end
    wait_idle(cyc);
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL maddu_nop_hi got %h want 00000000", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL maddu_nop_lo got %h want ffffffff", lo); end
`endif
    issue(4'd15, 32'h5555_5555, 32'd3);           // unused encoding
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nop_busy got %0b want 0", busy); end
    wait_idle(cyc);
`ifdef MDU_MADD_EN
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL nop_lo got %h want 00000000", lo); end
`else
    n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL nop_lo got %h want ffffffff", lo); end
`endif
  endtask

  task automatic test_reset_mid;
    issue(4'd4, 32'h0000_0055, 32'd0);
    issue(4'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);                    // now in the 4th busy cycle
    #2 reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %0b want 0", busy); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL rstmid_hi got %h want 00000000", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL rstmid_lo got %h want 00000000", lo); end
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstpost_busy got %0b want 0", busy); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL rstpost_hi got %h want 00000000", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL rstpost_lo got %h want 00000000", lo); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_start_during_run();
    test_madd();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
